// File: rtl/mult_seq_cell.sv
// mult_seq_cell: signed/unsigned multiplier reusing one LIMB_W x LIMB_W multiplier over N*N cycles
module mult_seq_cell #(
   parameter int DATA_W = 32,
   parameter int LIMB_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic              a_signed,
   input  logic              b_signed,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result_lo,
   output logic [DATA_W-1:0] result_hi
);
   localparam int N = DATA_W / LIMB_W;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   localparam int AW = 2 * DATA_W;
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   if (DATA_W % LIMB_W != 0) begin : g_bad_width
      $error("DATA_W must be a multiple of LIMB_W");
   end
   typedef enum logic [1:0] {IDLE, MUL, FIX, DONE} state_t;
   state_t state, state_nx;
   logic [N-1:0][LIMB_W-1:0] mag_a, mag_b;
   logic [AW-1:0] acc, res, pp;
   logic [2*LIMB_W-1:0] prod;
   logic [CW-1:0] i, j;
   logic neg, neg_a, neg_b, last;
   assign neg_a = a_signed & src_a[DATA_W-1];
   assign neg_b = b_signed & src_b[DATA_W-1];
   assign in_ready = state == IDLE;
   assign out_valid = state == DONE;
   assign {result_hi, result_lo} = res;
   always_comb begin
      last = i == LAST && j == LAST;
      prod = {{LIMB_W{1'b0}}, mag_a[i]} * {{LIMB_W{1'b0}}, mag_b[j]};
      pp = AW'(prod) << (LIMB_W * (int'(i) + int'(j)));
      state_nx = state == IDLE ? (in_valid ? MUL : IDLE) :
                 state == MUL  ? (last ? FIX : MUL) :
                 state == FIX  ? DONE : (out_ready ? IDLE : DONE);
   end
   // magnitudes are unsigned DATA_W, so the most-negative operand cannot overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         mag_a <= '0;
         mag_b <= '0;
         neg <= 1'b0;
         acc <= '0;
         res <= '0;
         i <= '0;
         j <= '0;
      end else if (en) begin
         state <= state_nx;
         if (state == IDLE && in_valid) begin
            mag_a <= neg_a ? -src_a : src_a;
            mag_b <= neg_b ? -src_b : src_b;
            neg <= neg_a ^ neg_b;
            acc <= '0;
            i <= '0;
            j <= '0;
         end
         if (state == MUL) begin
            acc <= acc + pp;
            j <= j == LAST ? '0 : j + CW'(1);
            i <= j == LAST ? i + CW'(1) : i;
         end
         if (state == FIX) res <= neg ? -acc : acc;
      end
   end
endmodule

// File: tb/tb_mult_seq_cell.sv
// tb_mult_seq_cell: random and scripted traffic on three widths, checked every cycle against an arithmetic model
module tb_mult_seq_cell;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int n_pass = 0;
   int n_chk = 0;
   int n_done[3];
   bit fin[3];

   task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   // full-precision signed product, truncated to 2*dw bits
   function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic sa, input logic sb, input int dw);
      logic signed [127:0] x, y, p;
      logic [63:0] m;
      m = dw == 64 ? '1 : (64'd1 << dw) - 64'd1;
      x = 128'(a & m);
      y = 128'(b & m);
      if (sa && a[dw-1]) x = x - (128'sd1 << dw);
      if (sb && b[dw-1]) y = y - (128'sd1 << dw);
      p = x * y;
      return dw == 64 ? p : p & ((128'd1 << (2 * dw)) - 128'd1);
   endfunction

   for (genvar k = 0; k < 3; k++) begin : g
      localparam int DW = k == 0 ? 32 : k == 1 ? 16 : 64;
      localparam int LW = k == 1 ? 8 : 16;
      localparam int NN = (DW / LW) * (DW / LW);
      localparam logic [DW-1:0] MSB = DW'(64'd1 << (DW - 1));
      logic reset = 1'b1, en = 1'b0, in_valid = 1'b0, a_signed = 1'b0, b_signed = 1'b0, out_ready = 1'b0;
      logic in_ready, out_valid;
      logic [DW-1:0] src_a = '0, src_b = '0, result_lo, result_hi;
      logic idle = 1'b1, m_valid = 1'b0;
      int cnt = 0;
      logic [2*DW-1:0] pend = '0, exp_res = '0;

      mult_seq_cell #(.DATA_W(DW), .LIMB_W(LW)) dut (
         .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_ready(in_ready),
         .src_a(src_a), .src_b(src_b), .a_signed(a_signed), .b_signed(b_signed),
         .out_valid(out_valid), .out_ready(out_ready), .result_lo(result_lo), .result_hi(result_hi)
      );

      // result appears NN+1 enabled edges after the accepting edge
      always @(posedge clk) begin
         if (reset) begin
            idle = 1'b1;
            m_valid = 1'b0;
            cnt = 0;
            exp_res = '0;
         end else if (en) begin
            if (idle && in_valid) begin
               pend = (2*DW)'(ref_mul(64'(src_a), 64'(src_b), a_signed, b_signed, DW));
               idle = 1'b0;
               cnt = NN + 1;
            end else if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  m_valid = 1'b1;
                  exp_res = pend;
               end
            end else if (m_valid && out_ready) begin
               m_valid = 1'b0;
               idle = 1'b1;
               n_done[k]++;
            end
         end
      end

      always @(negedge clk) begin
         check(in_ready === idle, $sformatf("cfg%0d in_ready", k), 128'(in_ready), 128'(idle));
         check(out_valid === m_valid, $sformatf("cfg%0d out_valid", k), 128'(out_valid), 128'(m_valid));
         check({result_hi, result_lo} === exp_res, $sformatf("cfg%0d result", k),
               128'({result_hi, result_lo}), 128'(exp_res));
      end

      task automatic step();
         @(posedge clk);
         #1;
      endtask

      function automatic logic [DW-1:0] pick();
         logic [63:0] r = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return MSB;
            3: return DW'(1);
            4: return ~MSB;
            default: return DW'(r);
         endcase
      endfunction

      task automatic txn(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sa, input logic sb,
                         input int stall, input int hold);
         src_a = a;
         src_b = b;
         a_signed = sa;
         b_signed = sb;
         in_valid = 1'b1;
         en = 1'b1;
         out_ready = 1'b0;
         step();
         src_a = pick();
         src_b = pick();
         a_signed = ~sa;
         b_signed = ~sb;
         step();
         en = 1'b0;
         repeat (stall) step();
         en = 1'b1;
         for (int t = 0; t < 200 && !m_valid; t++) step();
         repeat (hold) step();
         out_ready = 1'b1;
         in_valid = 1'b0;
         step();
         out_ready = 1'b0;
      endtask

      initial begin
         repeat (2) step();
         reset = 1'b0;
         txn('1, '1, 1'b0, 1'b0, 0, 0);
         txn('1, '1, 1'b1, 1'b1, 0, 0);
         txn(MSB, MSB, 1'b1, 1'b1, 0, 0);
         txn('1, '1, 1'b1, 1'b0, 0, 0);
         txn('0, MSB, 1'b1, 1'b1, 0, 0);
         txn(pick(), pick(), 1'b1, 1'b0, 3, 0);
         txn(pick(), pick(), 1'b0, 1'b1, 0, 5);
         src_a = pick();
         src_b = pick();
         in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         step();
         reset = 1'b1;
         step();
         reset = 1'b0;
         txn(DW'(7), DW'(6), 1'b0, 1'b0, 0, 0);
         for (int c = 0; c < 60000 && n_done[k] < 1000; c++) begin
            reset = $urandom_range(0, 299) == 0;
            en = $urandom_range(0, 5) != 0;
            in_valid = 1'($urandom);
            out_ready = $urandom_range(0, 2) != 0;
            src_a = pick();
            src_b = pick();
            a_signed = 1'($urandom);
            b_signed = 1'($urandom);
            step();
         end
         reset = 1'b0;
         in_valid = 1'b0;
         step();
         fin[k] = 1'b1;
      end
   end

   initial begin
      check(ref_mul(64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 1'b0, 32) == 128'hFFFFFFFE_00000001, "pin umax", 
            ref_mul(64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 1'b0, 32), 128'hFFFFFFFE_00000001);
      check(ref_mul(64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b1, 32) == 128'h1, "pin m1xm1",
            ref_mul(64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b1, 32), 128'h1);
      check(ref_mul(64'h80000000, 64'h80000000, 1'b1, 1'b1, 32) == 128'h40000000_00000000, "pin minxmin",
            ref_mul(64'h80000000, 64'h80000000, 1'b1, 1'b1, 32), 128'h40000000_00000000);
      check(ref_mul(64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b0, 32) == 128'hFFFFFFFF_00000001, "pin mixed",
            ref_mul(64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b0, 32), 128'hFFFFFFFF_00000001);
      check(ref_mul(64'h0, 64'h80000000, 1'b1, 1'b1, 32) == 128'h0, "pin zero",
            ref_mul(64'h0, 64'h80000000, 1'b1, 1'b1, 32), 128'h0);
      check(ref_mul(64'd7, 64'd6, 1'b0, 1'b0, 32) == 128'd42, "pin 7x6",
            ref_mul(64'd7, 64'd6, 1'b0, 1'b0, 32), 128'd42);
      check(ref_mul(64'h8000, 64'hFFFF, 1'b1, 1'b0, 16) == 128'h80008000, "pin w16",
            ref_mul(64'h8000, 64'hFFFF, 1'b1, 1'b0, 16), 128'h80008000);
      check(ref_mul('1, '1, 1'b1, 1'b1, 64) == 128'h1, "pin w64",
            ref_mul('1, '1, 1'b1, 1'b1, 64), 128'h1);
      for (int t = 0; t < 90000 && !(fin[0] && fin[1] && fin[2]); t++) @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         check(fin[k], $sformatf("cfg%0d finished", k), 128'(fin[k]), 128'd1);
         check(n_done[k] >= 1000, $sformatf("cfg%0d completions", k), 128'(n_done[k]), 128'd1000);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
